pipe_hazard_fwd: RTL

Parametrised hazard-tracking and operand-forwarding unit for the rv32 pipelines, successor to the fixed datahazard/forwarding pair. It sits beside decode and tracks every in-flight register write over DEPTH post-decode stages. It selects each decode operand from the register file or from the youngest matching stage result, and stalls decode when a producer's data is not yet available, such as a load before its data stage. It also keeps a saturating stall counter for performance monitoring.

---
 rtl/pipe_hazard_fwd.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_fwd.sv
// Hazard tracker and operand-forwarding unit for decode: follows in-flight register writes
// across DEPTH post-decode stages, forwards the youngest ready result and stalls on load-use.
module pipe_hazard_fwd #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  localparam int unsigned SELW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic [XLEN-1:0]       rf_rs1,
  input  logic [XLEN-1:0]       rf_rs2,
  input  logic [DEPTH*XLEN-1:0] stg_data,
  output logic [XLEN-1:0]       rs1_out,
  output logic [XLEN-1:0]       rs2_out,
  output logic [SELW-1:0]       rs1_sel,
  output logic [SELW-1:0]       rs2_sel,
  output logic                  stall,
  output logic [DEPTH-1:0]      inflight,
  output logic [15:0]           stall_cnt
);

  logic [DEPTH-1:0]      trk_v_q, trk_v_d;
  logic [DEPTH-1:0][4:0] trk_rd_q, trk_rd_d;
  logic [DEPTH-1:0]      trk_ld_q, trk_ld_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic                  rs1_hit, rs1_rdy, rs2_hit, rs2_rdy;
  logic [SELW-1:0]       rs1_sel_c, rs2_sel_c;
  int unsigned           rs1_idx, rs2_idx;
  logic                  issue;

  // Scan from the youngest stage so the most recent producer of addr wins.
  function automatic void lookup(
    input  logic                  used,
    input  logic [4:0]            addr,
    input  logic [DEPTH-1:0]      v,
    input  logic [DEPTH-1:0][4:0] rd,
    input  logic [DEPTH-1:0]      ld,
    output logic                  hit,
    output logic                  rdy,
    output logic [SELW-1:0]       sel,
    output int unsigned           idx
  );
    hit = 1'b0;
    rdy = 1'b1;
    sel = '0;
    idx = 0;
    if (used && addr != 5'd0) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!hit && v[k] && rd[k] == addr) begin
          hit = 1'b1;
          idx = k;
          rdy = !ld[k] || (k >= LOAD_STAGE);
        end
      end
    end
    if (hit && rdy) sel = SELW'(idx + 1);
  endfunction

  always_comb begin
    lookup(id_rs1_used, id_rs1, trk_v_q, trk_rd_q, trk_ld_q, rs1_hit, rs1_rdy, rs1_sel_c, rs1_idx);
    lookup(id_rs2_used, id_rs2, trk_v_q, trk_rd_q, trk_ld_q, rs2_hit, rs2_rdy, rs2_sel_c, rs2_idx);
  end

  always_comb begin
    rs1_sel  = rs1_sel_c;
    rs2_sel  = rs2_sel_c;
    rs1_out  = (rs1_hit && rs1_rdy) ? stg_data[rs1_idx*XLEN +: XLEN] : rf_rs1;
    rs2_out  = (rs2_hit && rs2_rdy) ? stg_data[rs2_idx*XLEN +: XLEN] : rf_rs2;
    stall    = id_valid && !flush && ((rs1_hit && !rs1_rdy) || (rs2_hit && !rs2_rdy));
    inflight = trk_v_q;
    stall_cnt = stall_cnt_q;
  end

  assign issue = id_valid && !stall && !flush && id_reg_wr && (id_rd != 5'd0);

  // The tracker always advances, even while decode is stalled.
  always_comb begin
    trk_v_d     = '0;
    trk_rd_d    = '0;
    trk_ld_d    = '0;
    trk_v_d[0]  = issue;
    trk_rd_d[0] = id_rd;
    trk_ld_d[0] = id_is_load;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      trk_v_d[k]  = trk_v_q[k-1];
      trk_rd_d[k] = trk_rd_q[k-1];
      trk_ld_d[k] = trk_ld_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trk_v_q     <= '0;
      trk_rd_q    <= '0;
      trk_ld_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_v_q     <= trk_v_d;
      trk_rd_q    <= trk_rd_d;
      trk_ld_q    <= trk_ld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
